// File: rtl/qam_rx_pkg.sv
// qam_rx_pkg: shared types for the QAM-16 receiver carrier-loop blocks.
// Holds the CORDIC scheduler state encoding, the core mode bit values and
// the two-way grant encoding used by cordic_sched and cordic_sched_arb.
package qam_rx_pkg;

  // Job FSM states of the CORDIC scheduler
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPT,
    WAIT
  } sched_state_e;

  // core_mode values seen by the CORDIC core
  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_ROT = 1'b1;

  // Arbiter grant encoding; deliberately matches the mode bit values
  typedef enum logic {
    GRANT_VEC = 1'b0,
    GRANT_ROT = 1'b1
  } grant_e;

  // Core mode for a granted requester
  function automatic logic grant_to_mode(input grant_e g);
    return (g == GRANT_ROT) ? MODE_ROT : MODE_VEC;
  endfunction

  // Requester identity of the job currently held in the core
  function automatic grant_e mode_to_grant(input logic m);
    return (m == MODE_ROT) ? GRANT_ROT : GRANT_VEC;
  endfunction

endpackage

// File: rtl/cordic_sched_arb.sv
// cordic_sched_arb: two-way arbiter between the vectoring (VEC) and
// rotation (ROT) requesters of the shared CORDIC core.
// Default build: round-robin on ties, using the last completed grant.
// With CORDIC_SCHED_ROT_PRIO_EN defined: fixed priority, ROT wins every tie
// and the last-grant history is ignored (VEC may starve).
module cordic_sched_arb
  import qam_rx_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_vec_req,
  input  logic   i_rot_req,
  input  logic   i_upd,
  input  grant_e i_upd_grant,
  output logic   o_valid,
  output grant_e o_grant
);

  grant_e r_last_grant;

  // Remember which requester completed last; reset favours VEC on the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GRANT_ROT;
    end else if (i_upd) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      r_last_grant <= i_upd_grant;
    end
  end

  // Pick a winner from the current request levels
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    o_valid = i_vec_req | i_rot_req;
    o_grant = GRANT_VEC;
`ifdef CORDIC_SCHED_ROT_PRIO_EN
    if (i_rot_req) begin
      o_grant = GRANT_ROT;
    end
`else
    if (i_vec_req && i_rot_req) begin
      o_grant = (r_last_grant == GRANT_ROT) ? GRANT_VEC : GRANT_ROT;
    end else if (i_rot_req) begin
      o_grant = GRANT_ROT;
    end
`endif
  end

endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: time-shares one iterative CORDIC core between the VEC
// (phase-error vectoring) and ROT (symbol derotation) requesters.
// A job is accepted in IDLE, loaded for one cycle, iterated for ITER cycles,
// captured into res_* and signalled with a done pulse; GAP idle cycles
// follow each job. Optional macro CORDIC_SCHED_ROT_PRIO_EN switches the
// arbiter to fixed ROT priority.
module cordic_sched
  import qam_rx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             vec_req,
  input  logic [WIDTH-1:0] vec_x,
  input  logic [WIDTH-1:0] vec_y,
  output logic             vec_ack,
  output logic             vec_done,
  input  logic             rot_req,
  input  logic [WIDTH-1:0] rot_x,
  input  logic [WIDTH-1:0] rot_y,
  input  logic [WIDTH-1:0] rot_z,
  output logic             rot_ack,
  output logic             rot_done,
  output logic             core_ld,
  output logic             core_ce,
  output logic             core_mode,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_y,
  output logic [WIDTH-1:0] core_z,
  input  logic [WIDTH-1:0] core_xo,
  input  logic [WIDTH-1:0] core_yo,
  input  logic [WIDTH-1:0] core_zo,
  output logic [WIDTH-1:0] res_x,
  output logic [WIDTH-1:0] res_y,
  output logic [WIDTH-1:0] res_z,
  output logic             busy
);

  localparam int              CNT_W     = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);
  localparam logic [2:0]      GAP_LAST  = 3'((GAP > 0) ? GAP - 1 : 0);

  sched_state_e     r_state;
  sched_state_e     w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_wcnt;

  logic             r_core_mode;
  logic [WIDTH-1:0] r_core_x;
  logic [WIDTH-1:0] r_core_y;
  logic [WIDTH-1:0] r_core_z;
  logic             r_vec_ack;
  logic             r_rot_ack;
  logic             r_vec_done;
  logic             r_rot_done;
  logic [WIDTH-1:0] r_res_x;
  logic [WIDTH-1:0] r_res_y;
  logic [WIDTH-1:0] r_res_z;

  logic             w_arb_valid;
  grant_e           w_arb_grant;
  logic             w_accept;
  logic             w_capture;
  logic             w_core_ld;
  logic             w_core_ce;
  logic             w_busy;

  assign w_accept  = (r_state == IDLE) && w_arb_valid && !flush;
  assign w_capture = (r_state == CAPT) && !flush;

  cordic_sched_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vec_req   (vec_req),
    .i_rot_req   (rot_req),
    .i_upd       (w_capture),
    .i_upd_grant (mode_to_grant(r_core_mode)),
    .o_valid     (w_arb_valid),
    .o_grant     (w_arb_grant)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_arb_valid) w_next_state = LOAD;
        LOAD:    w_next_state = RUN;
        RUN:     if (r_cnt == ITER_LAST) w_next_state = CAPT;
        CAPT:    w_next_state = (GAP == 0) ? IDLE : WAIT;
        WAIT:    if (r_wcnt == GAP_LAST) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Core strobes and busy, decoded from state; flush kills the strobes at once
  always_comb begin
    w_core_ld = (r_state == LOAD) && !flush;
    w_core_ce = (r_state == RUN) && !flush;
    w_busy    = (r_state != IDLE);
  end

  // Iteration counter (RUN) and gap counter (WAIT); both idle at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wcnt <= '0;
    end else begin
      r_cnt  <= (r_state == RUN && !flush) ? r_cnt + 1'b1 : '0;
      r_wcnt <= (r_state == WAIT && !flush) ? r_wcnt + 1'b1 : '0;
    end
  end

  // Operand capture and acknowledge on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well, because every output
      // must read zero while rst_n is low, not just the control state.
      r_core_mode <= MODE_VEC;
      r_core_x    <= '0;
      r_core_y    <= '0;
      r_core_z    <= '0;
      r_vec_ack   <= 1'b0;
      r_rot_ack   <= 1'b0;
    end else begin
      r_vec_ack <= w_accept && (w_arb_grant == GRANT_VEC);
      r_rot_ack <= w_accept && (w_arb_grant == GRANT_ROT);
      if (w_accept) begin
        r_core_mode <= grant_to_mode(w_arb_grant);
        if (w_arb_grant == GRANT_VEC) begin
          r_core_x <= vec_x;
          r_core_y <= vec_y;
          r_core_z <= '0;
        end else begin
          r_core_x <= rot_x;
          r_core_y <= rot_y;
          r_core_z <= rot_z;
        end
      end
    end
  end

  // Result capture and done pulse, aligned so done rises with valid res_*
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_x    <= '0;
      r_res_y    <= '0;
      r_res_z    <= '0;
      r_vec_done <= 1'b0;
      r_rot_done <= 1'b0;
    end else begin
      r_vec_done <= w_capture && (r_core_mode == MODE_VEC);
      r_rot_done <= w_capture && (r_core_mode == MODE_ROT);
      if (w_capture) begin
        r_res_x <= core_xo;
        r_res_y <= core_yo;
        r_res_z <= core_zo;
      end
    end
  end

  assign vec_ack   = r_vec_ack;
  assign rot_ack   = r_rot_ack;
  assign vec_done  = r_vec_done;
  assign rot_done  = r_rot_done;
  assign core_ld   = w_core_ld;
  assign core_ce   = w_core_ce;
  assign core_mode = r_core_mode;
  assign core_x    = r_core_x;
  assign core_y    = r_core_y;
  assign core_z    = r_core_z;
  assign res_x     = r_res_x;
  assign res_y     = r_res_y;
  assign res_z     = r_res_z;
  assign busy      = w_busy;

endmodule
